// File: rtl/prio_encoder_rr_if.sv
// rtl/prio_encoder_rr_if.sv - request/result handshake bundle for prio_encoder_rr
interface prio_encoder_rr_if #(parameter int N = 8);
  localparam int IDX_W = $clog2(N);

  logic             in_valid;
  logic             in_ready;
  logic [N-1:0]     req;
  logic             mode;
  logic             out_valid;
  logic             out_ready;
  logic [IDX_W-1:0] out_idx;
  logic [N-1:0]     out_onehot;
  logic             out_none;
  logic             out_multi;

  modport master (
    output in_valid, req, mode, out_ready,
    input  in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
  );

  modport slave (
    input  in_valid, req, mode, out_ready,
    output in_ready, out_valid, out_idx, out_onehot, out_none, out_multi
  );
endinterface

// File: rtl/prio_encoder_rr.sv
// rtl/prio_encoder_rr.sv - registered N-to-log2(N) encoder, fixed-priority or round-robin
module prio_encoder_rr #(
  parameter int N = 8
) (
  input logic            clk,
  input logic            rst,
  prio_encoder_rr_if.slave bus
);
  localparam int IDX_W = $clog2(N);

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] fp_idx;
  logic [IDX_W-1:0] rr_idx;
  logic [IDX_W-1:0] cand;
  logic [IDX_W-1:0] grant;
  logic             rr_found;
  logic             none;
  logic             multi;
  logic             accept;

  assign bus.in_ready = !bus.out_valid || bus.out_ready;
  assign accept       = bus.in_valid && bus.in_ready;

  always_comb begin
    fp_idx   = '0;
    rr_idx   = '0;
    cand     = '0;
    rr_found = 1'b0;
    // Ascending scan: the last hit is the highest set index.
    for (int i = 0; i < N; i++) begin
      if (bus.req[i]) fp_idx = IDX_W'(i);
    end
    // N is a power of two, so the index add wraps N-1 -> 0 by itself.
    for (int i = 0; i < N; i++) begin
      cand = ptr + IDX_W'(i);
      if (!rr_found && bus.req[cand]) begin
        rr_idx   = cand;
        rr_found = 1'b1;
      end
    end
    grant = bus.mode ? rr_idx : fp_idx;
    none  = ~|bus.req;
    multi = |(bus.req & (bus.req - N'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.out_valid  <= 1'b0;
      bus.out_idx    <= '0;
      bus.out_onehot <= '0;
      bus.out_none   <= 1'b0;
      bus.out_multi  <= 1'b0;
      ptr            <= '0;
    end else if (accept) begin
      bus.out_valid  <= 1'b1;
      bus.out_idx    <= none ? '0 : grant;
      bus.out_onehot <= none ? '0 : (N'(1) << grant);
      bus.out_none   <= none;
      bus.out_multi  <= multi;
      if (bus.mode && !none) ptr <= grant + IDX_W'(1);
    end else if (bus.out_ready) begin
      bus.out_valid  <= 1'b0;
    end
  end
endmodule

// File: tb/tb_prio_encoder_rr.sv
// tb/tb_prio_encoder_rr.sv - directed bench for prio_encoder_rr at N=8, 2 and 64
module tb_prio_encoder_rr;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  prio_encoder_rr_if #(.N(8))  a_if ();
  prio_encoder_rr_if #(.N(2))  b_if ();
  prio_encoder_rr_if #(.N(64)) c_if ();

  prio_encoder_rr #(.N(8))  u_a (.clk(clk), .rst(rst), .bus(a_if));
  prio_encoder_rr #(.N(2))  u_b (.clk(clk), .rst(rst), .bus(b_if));
  prio_encoder_rr #(.N(64)) u_c (.clk(clk), .rst(rst), .bus(c_if));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  initial begin
    a_if.in_valid = 0; a_if.req = '0; a_if.mode = 0; a_if.out_ready = 1;
    b_if.in_valid = 0; b_if.req = '0; b_if.mode = 0; b_if.out_ready = 1;
    c_if.in_valid = 0; c_if.req = '0; c_if.mode = 0; c_if.out_ready = 1;
    do_reset();

    check("rst_valid",  a_if.out_valid, 0);
    check("rst_idx",    a_if.out_idx, 0);
    check("rst_onehot", a_if.out_onehot, 0);
    check("rst_none",   a_if.out_none, 0);
    check("rst_multi",  a_if.out_multi, 0);
    check("rst_ready",  a_if.in_ready, 1);

    // walking one, fixed priority
    a_if.in_valid = 1;
    for (int i = 0; i < 8; i++) begin
      a_if.req = 8'(1) << i;
      step();
      check("walk_valid",  a_if.out_valid, 1);
      check("walk_idx",    a_if.out_idx, 64'(i));
      check("walk_onehot", a_if.out_onehot, 64'(1) << i);
      check("walk_multi",  a_if.out_multi, 0);
    end

    a_if.req = 8'h29;
    step();
    check("fp_idx",    a_if.out_idx, 5);
    check("fp_onehot", a_if.out_onehot, 64'h20);
    check("fp_multi",  a_if.out_multi, 1);
    check("fp_none",   a_if.out_none, 0);
    a_if.req = 8'h00;
    step();
    check("zero_valid",  a_if.out_valid, 1);
    check("zero_none",   a_if.out_none, 1);
    check("zero_idx",    a_if.out_idx, 0);
    check("zero_onehot", a_if.out_onehot, 0);
    check("zero_multi",  a_if.out_multi, 0);
    a_if.in_valid = 0;
    step();
    check("drain_valid", a_if.out_valid, 0);
    check("drain_none_kept", a_if.out_none, 1);

    // round-robin with wrap 7 -> 0
    do_reset();
    a_if.mode = 1; a_if.req = 8'h81; a_if.in_valid = 1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("rr_idx",   a_if.out_idx, (i % 2 == 0) ? 64'd0 : 64'd7);
      check("rr_multi", a_if.out_multi, 1);
    end

    // backpressure
    a_if.mode = 0; a_if.req = 8'h04;
    step();
    check("bp_first", a_if.out_idx, 2);
    a_if.out_ready = 0; a_if.req = 8'h10;
    for (int i = 0; i < 3; i++) begin
      step();
      check("bp_in_ready", a_if.in_ready, 0);
      check("bp_idx",      a_if.out_idx, 2);
      check("bp_valid",    a_if.out_valid, 1);
    end
    a_if.out_ready = 1;
    #1;
    check("bp_release_ready", a_if.in_ready, 1);
    step();
    check("bp_next_idx",   a_if.out_idx, 4);
    check("bp_next_valid", a_if.out_valid, 1);

    // reset mid-operation discards result and ptr
    do_reset();
    a_if.mode = 1; a_if.req = 8'h04; a_if.in_valid = 1;
    step();
    check("mid_grant", a_if.out_idx, 2);
    a_if.out_ready = 0;
    rst = 1;
    step();
    rst = 0;
    check("mid_valid", a_if.out_valid, 0);
    check("mid_ready", a_if.in_ready, 1);
    a_if.out_ready = 1; a_if.req = 8'hFF;
    step();
    check("mid_ptr0", a_if.out_idx, 0);
    // mode switch keeps ptr (now 1)
    a_if.mode = 0;
    step();
    check("sw_fp", a_if.out_idx, 7);
    a_if.mode = 1;
    step();
    check("sw_rr", a_if.out_idx, 1);
    a_if.in_valid = 0;

    // N=2
    b_if.in_valid = 1;
    for (int i = 0; i < 2; i++) begin
      b_if.req = 2'(1) << i;
      step();
      check("n2_walk", b_if.out_idx, 64'(i));
    end
    b_if.mode = 1; b_if.req = 2'b11;
    for (int i = 0; i < 3; i++) begin
      step();
      check("n2_rr", b_if.out_idx, 64'(i % 2));
    end
    b_if.in_valid = 0;

    // N=64
    c_if.in_valid = 1;
    for (int i = 0; i < 64; i++) begin
      c_if.req = 64'(1) << i;
      step();
      check("n64_walk", c_if.out_idx, 64'(i));
      check("n64_onehot", c_if.out_onehot, 64'(1) << i);
    end
    c_if.mode = 1; c_if.req = 64'h8000_0000_0000_0001;
    for (int i = 0; i < 3; i++) begin
      step();
      check("n64_rr", c_if.out_idx, (i % 2 == 0) ? 64'd0 : 64'd63);
    end
    c_if.in_valid = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/prio_encoder_rr.md
Name: prio_encoder_rr

Overview:
- Parametrised, registered N-to-log2(N) encoder. Generalises the team's 8-to-3 combinational encoder.
- Multi-hot inputs are resolved by one of two selectable schemes: fixed-priority (MSB wins) or round-robin.
- Results are delivered through a valid/ready output register.
- Sits between request sources (interrupt lines, FIFO-not-empty flags) and a downstream consumer that may stall.

Parameters:
- N, 8, number of request inputs; legal range 2..64, power of two.
- IDX_W, $clog2(N), width of the encoded index; derived, not to be overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  req is presented this cycle.
- in_ready  output  1  block can accept req this cycle.
- req  input  N  request vector; any number of bits may be set.
- mode  input  1  0 = fixed priority (highest index wins); 1 = round-robin. Sampled with req on acceptance.
- out_valid  output  1  result register holds an unconsumed result.
- out_ready  input  1  consumer takes the result this cycle.
- out_idx  output  IDX_W  encoded index of the granted bit.
- out_onehot  output  N  one-hot grant (1 << out_idx), or all zero when none.
- out_none  output  1  accepted req was all zeros.
- out_multi  output  1  accepted req had two or more bits set.

Behaviour:
- Reset (rst high at a clock edge):
  - out_valid=0, out_idx=0, out_onehot=0, out_none=0, out_multi=0.
  - Round-robin pointer ptr=0.
  - rst overrides any handshake in the same cycle, mid-transfer or not; pending results are discarded.
- in_ready = !out_valid || out_ready. It is combinational and has no dependence on in_valid.
- Accept: in_valid && in_ready at a clock edge. Result registered on that edge, so latency is 1 cycle (out_valid high the next cycle).
- Hold: out_valid && !out_ready keeps all out_* stable and in_ready=0. A req presented while stalled is not sampled.
- Consume: out_valid && out_ready with no new accept clears out_valid. out_idx/onehot/flags keep their last values.
- Back-to-back: consume and accept in the same cycle keep out_valid=1 with the new result. Full throughput is one result per cycle.
- mode 0 (fixed priority):
  - Grant the highest set index.
  - A one-hot req gives exactly the index of the set bit.
- mode 1 (round-robin):
  - Search starts at ptr, ascending, wrapping N-1 -> 0. The first set bit is granted.
  - After a grant g, ptr <= (g+1) mod N, so wrap-around at g=N-1 gives ptr=0.
- ptr update rules:
  - ptr updates only on an accepted, non-zero req in mode 1.
  - Mode-0 accepts and all-zero accepts leave ptr unchanged.
  - A mode switch does not reset ptr.
- All-zero req accepted: out_none=1, out_idx=0, out_onehot=0, out_multi=0, out_valid=1 (the result is still delivered).
- out_multi=1 iff popcount(req)>=2, in both modes.
- Invariant: out_onehot == (out_none ? 0 : 1<<out_idx).

Test Plan:
- Walking one, N=8, mode 0, out_ready=1: req 0x01,0x02,...,0x80 on consecutive cycles -> out_idx 0..7 one cycle later each, out_multi=0, out_valid continuously 1 after the first.
- Fixed priority multi-hot, mode 0: req=0x29 -> out_idx=5, out_onehot=0x20, out_multi=1. Then req=0x00 -> out_none=1, out_idx=0, out_onehot=0.
- Round-robin fairness, mode 1, after reset: req=0x81 held for 4 accepts -> out_idx 0,7,0,7 (ptr 1,0,1,0). Covers the wrap from 7 to ptr=0.
- Backpressure: accept req=0x04, hold out_ready=0 for 3 cycles while req changes to 0x10 -> in_ready=0 and out_idx stays 2. Raise out_ready with in_valid=1 -> next cycle out_idx=4, out_valid=1, no bubble.
- Reset mid-operation, mode 1: after grants leave ptr=3, assert rst with out_valid=1 and in_valid=1 -> next cycle out_valid=0 and in_ready=1. Then req=0xFF -> out_idx=0 (ptr was reset).
- Parameter sweep N=2 and N=64: the walking-one and round-robin scenarios pass. For N=64, round-robin wrap 63 -> 0 with req bits {0,63}.
